// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results and queued, formatted load responses
// into the single registered register-file write port.
module wb_stage #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LQ_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_addr_i,
    input  logic [XLEN-1:0] alu_rd_data_i,
    output logic            alu_stall_o,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [4:0]      lsu_rd_addr_i,
    input  logic [2:0]      lsu_funct3_i,
    input  logic [1:0]      lsu_byte_off_i,
    input  logic [XLEN-1:0] lsu_rdata_i,
    output logic            rd_wren,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic [31:0]     wb_count_o
);

    localparam int unsigned AW = $clog2(LQ_DEPTH);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    // load queue storage and pointers
    logic [4:0]      lq_addr_q [LQ_DEPTH];
    logic [XLEN-1:0] lq_data_q [LQ_DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [AW:0]     cnt_q, cnt_d;

    logic [SW-1:0]   starve_q, starve_d;
    logic            alu_stall_q, alu_stall_d;

    logic            rd_wren_q, rd_wren_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic [31:0]     wb_count_q, wb_count_d;

    logic            empty, full, push, pop, alu_sel;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] fmt_data;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW + 1)'(LQ_DEPTH));
    assign push    = lsu_valid_i && !full;
    assign alu_sel = !alu_stall_q && alu_valid_i;
    assign pop     = !empty && (alu_stall_q || !alu_valid_i);

    // load data formatting: byte/half extraction with sign or zero extension
    always_comb begin
        byte_sel = '0;
        case (lsu_byte_off_i)
            2'd0:    byte_sel = lsu_rdata_i[7:0];
            2'd1:    byte_sel = lsu_rdata_i[15:8];
            2'd2:    byte_sel = lsu_rdata_i[23:16];
            default: byte_sel = lsu_rdata_i[31:24];
        endcase
        half_sel = lsu_byte_off_i[1] ? lsu_rdata_i[31:16] : lsu_rdata_i[15:0];
        case (lsu_funct3_i)
            3'd0:    fmt_data = {{(XLEN - 8){byte_sel[7]}}, byte_sel};
            3'd1:    fmt_data = {{(XLEN - 16){half_sel[15]}}, half_sel};
            3'd4:    fmt_data = {{(XLEN - 8){1'b0}}, byte_sel};
            3'd5:    fmt_data = {{(XLEN - 16){1'b0}}, half_sel};
            default: fmt_data = lsu_rdata_i;
        endcase
    end

    // arbitration, starvation tracking and next-state computation
    always_comb begin
        cnt_d       = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        rd_wren_d   = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        starve_d    = '0;
        alu_stall_d = 1'b0;
        if (alu_sel) begin
            if (alu_rd_addr_i != '0) begin
                rd_wren_d = 1'b1;
                rd_addr_d = alu_rd_addr_i;
                rd_data_d = alu_rd_data_i;
            end
        end else if (pop) begin
            if (lq_addr_q[rd_ptr_q] != '0) begin
                rd_wren_d = 1'b1;
                rd_addr_d = lq_addr_q[rd_ptr_q];
                rd_data_d = lq_data_q[rd_ptr_q];
            end
        end
        // counter saturates at the limit; the stall pulse follows one cycle later
        if (!empty && !pop) begin
            if (starve_q == SW'(STARVE_LIMIT)) begin
                starve_d    = starve_q;
                alu_stall_d = 1'b1;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
        wb_count_d = wb_count_q + 32'(rd_wren_d);
    end

    // control and write-port registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            alu_stall_q <= 1'b0;
            rd_wren_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            wb_count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            alu_stall_q <= alu_stall_d;
            rd_wren_q   <= rd_wren_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            wb_count_q  <= wb_count_d;
        end
    end

    // queue storage write, no reset needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            lq_addr_q[wr_ptr_q] <= lsu_rd_addr_i;
            lq_data_q[wr_ptr_q] <= fmt_data;
        end
    end

    assign lsu_ready_o = !full;
    assign alu_stall_o = alu_stall_q;
    assign rd_wren     = rd_wren_q;
    assign rd_addr     = rd_addr_q;
    assign rd_data     = rd_data_q;
    assign wb_count_o  = wb_count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load formatting, ALU writes, starvation stall,
// x0 suppression, full-queue push rejection and asynchronous reset.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_addr_i;
    logic [31:0] alu_rd_data_i;
    logic        alu_stall_o;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_addr_i;
    logic [2:0]  lsu_funct3_i;
    logic [1:0]  lsu_byte_off_i;
    logic [31:0] lsu_rdata_i;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] wb_count_o;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [31:0] exp_cnt = '0;

    wb_stage #(.XLEN(32), .LQ_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .alu_valid_i    (alu_valid_i),
        .alu_rd_addr_i  (alu_rd_addr_i),
        .alu_rd_data_i  (alu_rd_data_i),
        .alu_stall_o    (alu_stall_o),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_rd_addr_i  (lsu_rd_addr_i),
        .lsu_funct3_i   (lsu_funct3_i),
        .lsu_byte_off_i (lsu_byte_off_i),
        .lsu_rdata_i    (lsu_rdata_i),
        .rd_wren        (rd_wren),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .wb_count_o     (wb_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] data);
        lsu_valid_i    = 1'b1;
        lsu_rd_addr_i  = rd;
        lsu_funct3_i   = f3;
        lsu_byte_off_i = off;
        lsu_rdata_i    = data;
    endtask

    // push one load with ALU idle, then check the write one cycle after the pop
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input logic [31:0] data,
                           input logic [31:0] exp_data);
        set_load(rd, f3, off, data);
        step();
        lsu_valid_i = 1'b0;
        step();
        exp_cnt++;
        chk({tag, "_wren"}, 32'(rd_wren), 32'd1);
        chk({tag, "_addr"}, 32'(rd_addr), 32'(rd));
        chk({tag, "_data"}, rd_data, exp_data);
        chk({tag, "_cnt"}, wb_count_o, exp_cnt);
    endtask

    initial begin
        rst_ni = 1'b0;
        alu_valid_i = 1'b0; alu_rd_addr_i = '0; alu_rd_data_i = '0;
        lsu_valid_i = 1'b0; lsu_rd_addr_i = '0; lsu_funct3_i = '0;
        lsu_byte_off_i = '0; lsu_rdata_i = '0;
        step(); step();
        chk("rst_wren",  32'(rd_wren), 32'd0);
        chk("rst_addr",  32'(rd_addr), 32'd0);
        chk("rst_data",  rd_data, 32'd0);
        chk("rst_ready", 32'(lsu_ready_o), 32'd1);
        chk("rst_stall", 32'(alu_stall_o), 32'd0);
        chk("rst_cnt",   wb_count_o, 32'd0);
        rst_ni = 1'b1;
        step();

        // ALU write with no loads pending
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd3; alu_rd_data_i = 32'hA5;
        step();
        alu_valid_i = 1'b0;
        exp_cnt++;
        chk("alu_wren", 32'(rd_wren), 32'd1);
        chk("alu_addr", 32'(rd_addr), 32'd3);
        chk("alu_data", rd_data, 32'hA5);
        chk("alu_cnt",  wb_count_o, 32'd1);

        // load formatting
        do_load("lb",     5'd5, 3'd0, 2'd2, 32'h1280_3456, 32'hFFFF_FF80);
        do_load("lbu",    5'd5, 3'd4, 2'd2, 32'h1280_3456, 32'h0000_0080);
        do_load("lhu",    5'd5, 3'd5, 2'd3, 32'h1280_3456, 32'h0000_1280);
        do_load("lh",     5'd6, 3'd1, 2'd1, 32'h1234_F00D, 32'hFFFF_F00D);
        do_load("lw",     5'd7, 3'd2, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("f3_6",   5'd8, 3'd6, 2'd1, 32'h8765_4321, 32'h8765_4321);
        step();
        chk("idle_wren", 32'(rd_wren), 32'd0);
        chk("idle_addr", 32'(rd_addr), 32'd8);
        chk("idle_data", rd_data, 32'h8765_4321);

        // starvation: two loads queued behind continuous ALU traffic
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd7; alu_rd_data_i = 32'h100;
        set_load(5'd10, 3'd2, 2'd0, 32'h1111);
        step();
        exp_cnt++;
        chk("sv_alu0_addr", 32'(rd_addr), 32'd7);
        chk("sv_ready1",    32'(lsu_ready_o), 32'd1);
        set_load(5'd11, 3'd2, 2'd0, 32'h2222);
        step();
        exp_cnt++;
        lsu_valid_i = 1'b0;
        chk("sv_ready0",    32'(lsu_ready_o), 32'd0);
        chk("sv_alu1_addr", 32'(rd_addr), 32'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_cnt++;
            chk("sv_wait_stall", 32'(alu_stall_o), 32'd0);
            chk("sv_wait_addr",  32'(rd_addr), 32'd7);
        end
        step();
        exp_cnt++;
        chk("sv_stall_hi",   32'(alu_stall_o), 32'd1);
        chk("sv_stall_rdy",  32'(lsu_ready_o), 32'd0);
        step();
        exp_cnt++;
        alu_valid_i = 1'b0;
        chk("sv_head_addr",  32'(rd_addr), 32'd10);
        chk("sv_head_data",  rd_data, 32'h1111);
        chk("sv_stall_lo",   32'(alu_stall_o), 32'd0);
        chk("sv_ready_back", 32'(lsu_ready_o), 32'd1);
        step();
        exp_cnt++;
        chk("sv_b_addr", 32'(rd_addr), 32'd11);
        chk("sv_b_data", rd_data, 32'h2222);
        chk("sv_cnt",    wb_count_o, exp_cnt);

        // writes to x0 are consumed but not performed
        set_load(5'd0, 3'd2, 2'd0, 32'h5555);
        step();
        lsu_valid_i = 1'b0;
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd0; alu_rd_data_i = 32'h77;
        step();
        chk("x0_alu_wren", 32'(rd_wren), 32'd0);
        alu_valid_i = 1'b0;
        step();
        chk("x0_ld_wren", 32'(rd_wren), 32'd0);
        step();
        chk("x0_idle_wren", 32'(rd_wren), 32'd0);
        chk("x0_ready",     32'(lsu_ready_o), 32'd1);
        chk("x0_cnt",       wb_count_o, exp_cnt);
        chk("x0_addr_hold", 32'(rd_addr), 32'd11);
        chk("x0_data_hold", rd_data, 32'h2222);

        // full queue: pop with simultaneous valid load, push must be refused
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd7; alu_rd_data_i = 32'h200;
        set_load(5'd12, 3'd2, 2'd0, 32'hC);
        step();
        exp_cnt++;
        set_load(5'd13, 3'd2, 2'd0, 32'hD);
        step();
        exp_cnt++;
        chk("full_ready0", 32'(lsu_ready_o), 32'd0);
        alu_valid_i = 1'b0;
        set_load(5'd14, 3'd2, 2'd0, 32'hE);
        step();
        exp_cnt++;
        lsu_valid_i = 1'b0;
        chk("full_pop_addr", 32'(rd_addr), 32'd12);
        chk("full_pop_data", rd_data, 32'hC);
        chk("full_ready1",   32'(lsu_ready_o), 32'd1);
        step();
        exp_cnt++;
        chk("full_d_addr", 32'(rd_addr), 32'd13);
        chk("full_d_data", rd_data, 32'hD);
        step();
        chk("full_e_dropped", 32'(rd_wren), 32'd0);
        chk("full_cnt",       wb_count_o, exp_cnt);

        // asynchronous reset with two loads queued
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd7; alu_rd_data_i = 32'h300;
        set_load(5'd15, 3'd2, 2'd0, 32'hF);
        step();
        set_load(5'd16, 3'd2, 2'd0, 32'h10);
        step();
        chk("ar_pre_ready", 32'(lsu_ready_o), 32'd0);
        chk("ar_pre_wren",  32'(rd_wren), 32'd1);
        #2;
        rst_ni = 1'b0;
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        #1;
        chk("ar_wren",  32'(rd_wren), 32'd0);
        chk("ar_addr",  32'(rd_addr), 32'd0);
        chk("ar_data",  rd_data, 32'd0);
        chk("ar_ready", 32'(lsu_ready_o), 32'd1);
        chk("ar_stall", 32'(alu_stall_o), 32'd0);
        chk("ar_cnt",   wb_count_o, 32'd0);
        step();
        rst_ni = 1'b1;
        step();
        chk("ar_post_wren0", 32'(rd_wren), 32'd0);
        step();
        chk("ar_post_wren1", 32'(rd_wren), 32'd0);
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd9; alu_rd_data_i = 32'h42;
        step();
        alu_valid_i = 1'b0;
        chk("ar_new_addr", 32'(rd_addr), 32'd9);
        chk("ar_new_cnt",  wb_count_o, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
